program_counter_stack: RTL and testbench
========================================

# program_counter_stack

Parametrised program counter with an integrated return-address stack for subroutine CALL/RET, the next-generation PC for the SAP-2 datapath. Sits between the control sequencer (which issues `inr`, `load`, `call`, `ret`) and the memory address register (fed from `out`). Generalises the plain increment/load PC in address width, adds a configurable-depth hardware stack with full/empty status and sticky error flags, and optionally supports PC-relative branches.

## Interface
- ADDR_W, 16, width of PC, `data_in`, and stack entries.
- DEPTH, 4, return-stack entries; must be ≥ 2.
- RESET_VEC, 0, PC value loaded on reset.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; asserting low immediately forces reset state.
- inr  in  1  increment PC.
- load  in  1  load PC from `data_in` (JMP).
- call  in  1  push current PC, then load `data_in`.
- ret  in  1  pop the top of stack into PC.
- clr_err  in  1  synchronous clear of `ovf` and `unf`.
- data_in  in  ADDR_W  jump/call target.
- out  out  ADDR_W  current PC, driven directly from the register.
- depth  out  $clog2(DEPTH+1)  number of valid stack entries.
- full  out  1  `depth == DEPTH`.
- empty  out  1  `depth == 0`.
- ovf  out  1  sticky flag, set when `call` is issued while full.
- unf  out  1  sticky flag, set when `ret` is issued while empty.

## Operation
- Command priority when several inputs are high in one cycle: `call` > `ret` > `load` > `inr`. Only the winner acts; the losers are ignored.
- `inr`: PC ← PC + 1 modulo 2^ADDR_W. 0xFFFF wraps to 0x0000 at the default width.
- `load`: PC ← `data_in`. The stack is untouched.
- `call` when not full:
  - stack[depth] ← PC.
  - depth ← depth + 1.
  - PC ← `data_in`.
  - The sequencer has already advanced PC past the operand, so the pushed value is the return address.
- `call` when full:
  - No push, and PC is unchanged.
  - `ovf` ← 1.
- `ret` when not empty:
  - PC ← stack[depth−1].
  - depth ← depth − 1.
  - The popped slot's contents are don't-care afterwards.
- `ret` when empty:
  - PC is unchanged and depth stays 0.
  - `unf` ← 1.
- `clr_err`:
  - Clears `ovf` and `unf`.
  - If the same cycle also produces a new error, the set wins.
- No command: all state holds.
- Stack storage is a register array indexed by `depth`. There is no circular wrap; overflow never corrupts existing entries.

## Timing
- Reset state (asynchronous on `rst` low, held while low):
  - PC = RESET_VEC, so `out` = RESET_VEC.
  - depth = 0, empty = 1, full = 0.
  - ovf = 0, unf = 0.
  - All stack entries = 0.
- Release of `rst` is synchronous to `clk`. The first command is accepted at the first rising edge after `rst` goes high.
- Latency: every command takes effect at the rising edge where it is sampled. `out`, `depth`, and the flags reflect it immediately after that edge.
- `full` and `empty` are combinational from `depth`. `ovf` and `unf` are registered.
- Back-to-back `call`/`ret` on consecutive cycles is fully supported. A `ret` in the cycle after a `call` returns the value just pushed.
- Reset asserted mid-sequence (e.g. depth = 3) discards all stack contents. There is no recovery.

## Configuration
- `PC_REL_BRANCH_EN` defined:
  - Adds the input `rel` (1 bit) and the input `offset` (8 bits, two's complement).
  - `rel`: PC ← PC + sign-extended `offset`, modulo 2^ADDR_W.
  - Priority is `call` > `ret` > `rel` > `load` > `inr`.
- `PC_REL_BRANCH_EN` undefined: the ports `rel` and `offset` do not exist, and behaviour is exactly as described above.

## Test plan
- Reset with `rst` = 0 asynchronously mid-cycle -> `out` = 0x0000, depth = 0, empty = 1, ovf = unf = 0, without waiting for a clock edge.
- PC = 0xFFFE, `inr` for 3 cycles -> `out` = 0xFFFF, then 0x0000, then 0x0001.
- PC = 0x0010; `call` 0x0100; `call` 0x0200; `ret`; `ret` -> PC sequence 0x0100, 0x0200, 0x0100, 0x0010; depth 1, 2, 1, 0.
- DEPTH = 4: 5 calls, then `ret` on each of the next 5 cycles:
  - After the 5th call, `ovf` = 1 and PC still equals the 4th call's target.
  - The 4 rets return the correct addresses, and the 5th ret sets `unf` = 1.
  - `clr_err` then clears both flags.
- `call`, `ret`, `load`, and `inr` all high with depth = 1 -> only the call executes: depth = 2, PC = `data_in`.
- With `PC_REL_BRANCH_EN`: PC = 0x0005, `rel` with `offset` = 0xF8 (−8) -> PC = 0xFFFD.

Source files
------------

// File: rtl/program_counter_stack.sv
// SAP-2 program counter with return-address stack for CALL/RET.
// Optional PC-relative branch when PC_REL_BRANCH_EN is defined.
module program_counter_stack #(
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int               DW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inr,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic              clr_err,
`ifdef PC_REL_BRANCH_EN
  input  logic              rel,
  input  logic [7:0]        offset,
`endif
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] out,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] stk [DEPTH];
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DW-1:0]     dep_nxt;
  logic              push;
  logic              set_ovf;
  logic              set_unf;
  logic              do_call;
  logic              do_ret;
  logic              do_rel;
  logic              do_load;
  logic              do_inr;
  logic [ADDR_W-1:0] rel_tgt;

  assign out   = pc;
  assign full  = (depth == DMAX);
  assign empty = (depth == '0);

`ifdef PC_REL_BRANCH_EN
  assign rel_tgt = pc + {{(ADDR_W-8){offset[7]}}, offset};
  assign do_rel  = !call && !ret && rel;
`else
  assign rel_tgt = pc;
  assign do_rel  = 1'b0;
`endif

  assign do_call = call;
  assign do_ret  = !call && ret;
  assign do_load = !call && !ret && !do_rel && load;
  assign do_inr  = !call && !ret && !do_rel && !load && inr;

  // top-of-stack read: entry at depth-1
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i + 1)) top = stk[i];
    end
  end

  // winning command decides next PC, depth and error sets
  always_comb begin
    pc_nxt  = pc;
    dep_nxt = depth;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (1'b1)
      do_call: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          push    = 1'b1;
          dep_nxt = depth + 1'b1;
          pc_nxt  = data_in;
        end
      end
      do_ret: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          dep_nxt = depth - 1'b1;
          pc_nxt  = top;
        end
      end
      do_rel:  pc_nxt = rel_tgt;
      do_load: pc_nxt = data_in;
      do_inr:  pc_nxt = pc + 1'b1;
      default: ;
    endcase
  end

  // PC, depth and sticky flags; a new error beats clr_err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_VEC;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      depth <= dep_nxt;
      if (set_ovf)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (set_unf)      unf <= 1'b1;
      else if (clr_err) unf <= 1'b0;
    end
  end

  // return stack storage, written at index depth on push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth == DW'(i)) stk[i] <= pc;
      end
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (DEPTH=4, ADDR_W=16).
// Build with PC_REL_BRANCH_EN to also exercise relative branches.
module tb_program_counter_stack;

  logic        clk;
  logic        rst;
  logic        inr, load, call, ret, clr_err;
  logic [15:0] data_in;
  logic [15:0] out;
  logic [2:0]  depth;
  logic        full, empty, ovf, unf;
`ifdef PC_REL_BRANCH_EN
  logic        rel;
  logic [7:0]  offset;
`endif

  int ncmp = 0;
  int nfail = 0;

  program_counter_stack #(.ADDR_W(16), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .inr(inr), .load(load), .call(call),
    .ret(ret), .clr_err(clr_err),
`ifdef PC_REL_BRANCH_EN
    .rel(rel), .offset(offset),
`endif
    .data_in(data_in), .out(out), .depth(depth), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inr = 0; load = 0; call = 0; ret = 0; clr_err = 0;
`ifdef PC_REL_BRANCH_EN
    rel = 0; offset = 0;
`endif
  endtask

  // apply current inputs for one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_load(input logic [15:0] a);
    load = 1; data_in = a; step();
  endtask

  task automatic do_call(input logic [15:0] a);
    call = 1; data_in = a; step();
  endtask

  task automatic do_ret();
    ret = 1; step();
  endtask

  task automatic st(input string tag, input logic [15:0] pc,
                    input logic [2:0] d, input logic f, input logic e,
                    input logic o, input logic u);
    chk({tag, ".out"}, out, pc);
    chk({tag, ".depth"}, {13'd0, depth}, {13'd0, d});
    chk({tag, ".full"}, {15'd0, full}, {15'd0, f});
    chk({tag, ".empty"}, {15'd0, empty}, {15'd0, e});
    chk({tag, ".ovf"}, {15'd0, ovf}, {15'd0, o});
    chk({tag, ".unf"}, {15'd0, unf}, {15'd0, u});
  endtask

  initial begin
    idle();
    data_in = 0;
    rst = 0;
    #2;
    st("rst0", 16'h0000, 3'd0, 0, 1, 0, 0);
    #5 rst = 1;
    @(negedge clk);

    // increment wrap
    do_load(16'hFFFE);
    chk("ld_fffe", out, 16'hFFFE);
    inr = 1; step(); chk("inr1", out, 16'hFFFF);
    inr = 1; step(); chk("inr2", out, 16'h0000);
    inr = 1; step(); chk("inr3", out, 16'h0001);
    step(); chk("hold", out, 16'h0001);

    // nested call/ret
    do_load(16'h0010);
    do_call(16'h0100); st("c1", 16'h0100, 3'd1, 0, 0, 0, 0);
    do_call(16'h0200); st("c2", 16'h0200, 3'd2, 0, 0, 0, 0);
    do_ret();          st("r1", 16'h0100, 3'd1, 0, 0, 0, 0);
    do_ret();          st("r2", 16'h0010, 3'd0, 0, 1, 0, 0);

    // overflow / underflow with DEPTH=4
    do_load(16'h0000);
    do_call(16'h1000); st("f1", 16'h1000, 3'd1, 0, 0, 0, 0);
    do_call(16'h2000); st("f2", 16'h2000, 3'd2, 0, 0, 0, 0);
    do_call(16'h3000); st("f3", 16'h3000, 3'd3, 0, 0, 0, 0);
    do_call(16'h4000); st("f4", 16'h4000, 3'd4, 1, 0, 0, 0);
    do_call(16'h5000); st("f5", 16'h4000, 3'd4, 1, 0, 1, 0);
    do_ret(); st("p1", 16'h3000, 3'd3, 0, 0, 1, 0);
    do_ret(); st("p2", 16'h2000, 3'd2, 0, 0, 1, 0);
    do_ret(); st("p3", 16'h1000, 3'd1, 0, 0, 1, 0);
    do_ret(); st("p4", 16'h0000, 3'd0, 0, 1, 1, 0);
    do_ret(); st("p5", 16'h0000, 3'd0, 0, 1, 1, 1);
    clr_err = 1; step(); st("clr", 16'h0000, 3'd0, 0, 1, 0, 0);

    // new error in same cycle as clr_err: set wins
    ret = 1; clr_err = 1; step();
    st("setwin", 16'h0000, 3'd0, 0, 1, 0, 1);
    clr_err = 1; step(); chk("clr2", {15'd0, unf}, 16'd0);

    // priority
    do_load(16'h0050);
    do_call(16'h0700);
    call = 1; ret = 1; load = 1; inr = 1; data_in = 16'h0900; step();
    st("prio", 16'h0900, 3'd2, 0, 0, 0, 0);
    ret = 1; load = 1; inr = 1; data_in = 16'h0ABC; step();
    st("ret_win", 16'h0700, 3'd1, 0, 0, 0, 0);
    load = 1; inr = 1; data_in = 16'h0ABC; step();
    chk("load_win", out, 16'h0ABC);
    do_ret(); st("ret_b", 16'h0050, 3'd0, 0, 1, 0, 0);

`ifdef PC_REL_BRANCH_EN
    do_load(16'h0005);
    rel = 1; offset = 8'hF8; step();
    chk("rel_neg", out, 16'hFFFD);
    rel = 1; load = 1; offset = 8'h10; data_in = 16'h1234; step();
    chk("rel_win", out, 16'h000D);
`endif

    // asynchronous reset mid-cycle with stacked entries and error
    do_load(16'h0123);
    do_call(16'h0200);
    do_call(16'h0300);
    do_call(16'h0400);
    ret = 0; clr_err = 0;
    do_call(16'h0500);
    do_call(16'h0600);
    st("pre_rst", 16'h0500, 3'd4, 1, 0, 1, 0);
    #2 rst = 0;
    #1 st("async_rst", 16'h0000, 3'd0, 0, 1, 0, 0);
    inr = 1; step();
    chk("rst_hold", out, 16'h0000);
    @(negedge clk);
    rst = 1;
    do_ret(); st("post_rst", 16'h0000, 3'd0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
